ext_bus_bridge: RTL and testbench
=================================

EXT_BUS_BRIDGE -- requirements
Module: ext_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 15: max clk cycles in REQ before forced completion.
REQ-002 Parameter TIMEOUT_DATA, default 8'hEA: read data returned on timeout (6502 NOP).
REQ-003 clk  in  1  system clock, the same clock that drives clock_generator; one clock only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 clk_cpu  in  1  CPU phase level, generated synchronously to clk, each level held >=2 clk cycles.
REQ-006 addr_pins  in  8  CPU uo_out: address low byte while clk_cpu=0, high byte while clk_cpu=1.
REQ-007 data_pins_out  in  8  CPU uio_out: {7'b0,rw} while clk_cpu=0, write data while clk_cpu=1.
REQ-008 data_pins_in  out  8  to CPU uio_in: read data.
REQ-009 mem_req  out  1  memory request, level, held until ack/timeout/abort.
REQ-010 mem_we  out  1  1=write, 0=read; valid while mem_req.
REQ-011 mem_addr  out  16  transfer address; valid while mem_req.
REQ-012 mem_wdata  out  8  write data; valid while mem_req.
REQ-013 mem_ack  in  1  one-cycle completion from memory.
REQ-014 mem_rdata  in  8  read data, valid with mem_ack.
REQ-015 timeout_err  out  1  sticky: a transfer timed out.
REQ-016 late_err  out  1  sticky: CPU cycle ended before completion.
REQ-017 cycle_count  out  16  count of completed transfers.

Function
REQ-018 Bridge SHALL register clk_cpu into phi_d each clk; rise = clk_cpu & ~phi_d, fall = ~clk_cpu & phi_d.
REQ-019 FSM states SHALL be IDLE, LO, REQ, HOLD.
REQ-020 IDLE: wait for fall; on fall -> LO and capture as in REQ-021 that same cycle; rise ignored.
REQ-021 LO: every clk latch addr_lo <= addr_pins, rw_q <= data_pins_out[0].
REQ-022 LO on rise: latch addr_hi <= addr_pins, wdata_q <= data_pins_out -> REQ; mem_req high from the next clk.
REQ-023 REQ: mem_req=1, mem_we=~rw_q, mem_addr={addr_hi,addr_lo}, mem_wdata=wdata_q, all stable; wait counter increments each cycle.
REQ-024 REQ on mem_ack: if read, rdata_q <= mem_rdata; cycle_count +1 -> HOLD.
REQ-025 REQ when wait counter reaches TIMEOUT with no ack: if read, rdata_q <= TIMEOUT_DATA; timeout_err <= 1; cycle_count +1 -> HOLD.
REQ-026 REQ on fall: late_err <= 1 -> LO with capture; if mem_ack in same cycle, read data still loads rdata_q and cycle_count +1.
REQ-027 Priority in REQ: fall > mem_ack > timeout.
REQ-028 HOLD: mem_req=0; on fall -> LO with capture.
REQ-029 data_pins_in SHALL always equal rdata_q; rdata_q changes only per REQ-024/025/026.
REQ-030 Writes SHALL never modify rdata_q.
REQ-031 mem_req SHALL deassert the clk after ack, timeout or fall; never asserted outside REQ.
REQ-032 Wait counter SHALL clear on REQ entry; width >= clog2(TIMEOUT+1).
REQ-033 cycle_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-034 timeout_err and late_err SHALL clear only on rst.

Reset
REQ-035 On rst: state=IDLE, phi_d=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_q=0, data_pins_in=0, errors=0, cycle_count=0, counter=0.
REQ-036 rst asserted mid-REQ SHALL drop mem_req the next clk with no count or error update.
REQ-037 After rst release the first transfer SHALL begin only at a fall.

Verification
REQ-038 Read: lo=8'h34, rw=1, hi=8'h12; ack 3 clk after mem_req with rdata 8'hA9 -> mem_addr=16'h1234, mem_we=0, data_pins_in=8'hA9 before next fall, cycle_count=1.
REQ-039 Write: lo=8'h00, rw=0, hi=8'h02, data 8'h5C -> mem_we=1, mem_addr=16'h0200, mem_wdata=8'h5C; data_pins_in unchanged.
REQ-040 No ack, TIMEOUT=15 -> mem_req high exactly 15 clk, data_pins_in=8'hEA, timeout_err=1.
REQ-041 Fall while in REQ, with mem_ack same cycle -> late_err=1, rdata_q loaded, new LO capture that cycle.
REQ-042 rst pulsed during REQ -> next clk mem_req=0, all outputs at reset values, no transfer until a fall.
REQ-043 Preload cycle_count 16'hFFFF via 65535 transfers -> one more gives 16'h0000.

Source files
------------

// File: rtl/ext_bus_bridge_if.sv
// ext_bus_bridge_if
// Memory-side request/acknowledge bus of the external bus bridge.
//   mem_req   : level request, held until completion or abort
//   mem_we    : 1 = write, 0 = read (valid while mem_req)
//   mem_addr  : 16-bit transfer address (valid while mem_req)
//   mem_wdata : write data (valid while mem_req)
//   mem_ack   : one-cycle completion strobe from memory
//   mem_rdata : read data, valid with mem_ack
// The bridge uses the master modport; the memory uses the slave modport.
interface ext_bus_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ext_bus_bridge.sv
// ext_bus_bridge
// Turns the multiplexed pin bus of a 6502-style CPU into single memory
// requests. The address low byte and rw flag are taken while clk_cpu is low,
// the high byte and write data at the rising phase edge; the request then
// runs until memory acknowledges, a timeout expires or the CPU starts its
// next cycle.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   clk_cpu         : CPU phase level, synchronous to clk
//   addr_pins       : address low byte (clk_cpu=0) / high byte (clk_cpu=1)
//   data_pins_out   : {7'b0,rw} (clk_cpu=0) / write data (clk_cpu=1)
//   data_pins_in    : read data returned to the CPU
//   bus             : memory request/acknowledge bus (master side)
//   timeout_err     : sticky, a request timed out
//   late_err        : sticky, the CPU cycle ended before completion
//   cycle_count     : completed transfers, wraps at 16 bits
module ext_bus_bridge #(
    parameter int         TIMEOUT      = 15,
    parameter logic [7:0] TIMEOUT_DATA = 8'hEA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_cpu,
    input  logic [7:0]        addr_pins,
    input  logic [7:0]        data_pins_out,
    output logic [7:0]        data_pins_in,
    ext_bus_bridge_if.master  bus,
    output logic              timeout_err,
    output logic              late_err,
    output logic [15:0]       cycle_count
);
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen on the last allowed request cycle: the request
    // therefore stays up for exactly TIMEOUT cycles.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_REQ  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t            state_r;
    logic              phi_d_r;
    logic [7:0]        addr_lo_r;
    logic              rw_r;
    logic [7:0]        rdata_r;
    logic [WAIT_W-1:0] wait_r;
    logic              rise_s;
    logic              fall_s;

    assign rise_s       = clk_cpu & ~phi_d_r;
    assign fall_s       = ~clk_cpu & phi_d_r;
    assign data_pins_in = rdata_r;

    // Phase tracking, request FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            phi_d_r       <= 1'b0;
            addr_lo_r     <= 8'h00;
            rw_r          <= 1'b0;
            rdata_r       <= 8'h00;
            wait_r        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 16'h0000;
            bus.mem_wdata <= 8'h00;
            timeout_err   <= 1'b0;
            late_err      <= 1'b0;
            cycle_count   <= 16'h0000;
        end else begin
            phi_d_r <= clk_cpu;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r   <= ST_LO;
                        addr_lo_r <= addr_pins;
                        rw_r      <= data_pins_out[0];
                    end
                end
                ST_LO: begin
                    if (rise_s) begin
                        // Pins already show the high phase on this cycle, so
                        // the low byte is not re-captured here.
                        state_r       <= ST_REQ;
                        wait_r        <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= ~rw_r;
                        bus.mem_addr  <= {addr_pins, addr_lo_r};
                        bus.mem_wdata <= data_pins_out;
                    end else begin
                        addr_lo_r <= addr_pins;
                        rw_r      <= data_pins_out[0];
                    end
                end
                ST_REQ: begin
                    wait_r <= wait_r + WAIT_W'(1);
                    if (fall_s) begin
                        // CPU moved on: abort, but keep a same-cycle ack.
                        state_r     <= ST_LO;
                        bus.mem_req <= 1'b0;
                        late_err    <= 1'b1;
                        addr_lo_r   <= addr_pins;
                        rw_r        <= data_pins_out[0];
                        if (bus.mem_ack) begin
                            cycle_count <= cycle_count + 16'd1;
                            if (rw_r) begin
                                rdata_r <= bus.mem_rdata;
                            end
                        end
                    end else if (bus.mem_ack) begin
                        state_r     <= ST_HOLD;
                        bus.mem_req <= 1'b0;
                        cycle_count <= cycle_count + 16'd1;
                        if (rw_r) begin
                            rdata_r <= bus.mem_rdata;
                        end
                    end else if (wait_r == WAIT_LAST) begin
                        state_r     <= ST_HOLD;
                        bus.mem_req <= 1'b0;
                        timeout_err <= 1'b1;
                        cycle_count <= cycle_count + 16'd1;
                        if (rw_r) begin
                            rdata_r <= TIMEOUT_DATA;
                        end
                    end
                end
                ST_HOLD: begin
                    if (fall_s) begin
                        state_r   <= ST_LO;
                        addr_lo_r <= addr_pins;
                        rw_r      <= data_pins_out[0];
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ext_bus_bridge.sv
// tb_ext_bus_bridge
// Drives CPU bus cycles (low phase, high phase, next fall) into the bridge,
// answers requests from a small memory responder, and compares the outcome
// of every CPU cycle with a table of hand-computed values and with a
// transaction-level model for random cycles.
module tb_ext_bus_bridge;
    localparam int         TIMEOUT      = 15;
    localparam logic [7:0] TIMEOUT_DATA = 8'hEA;
    localparam int         NT           = 11;
    localparam int         NR           = 40;
    localparam int         WRAP_IDX     = NT + NR;
    localparam int         NV           = NT + NR + 2;

    typedef struct {
        logic [7:0]  lo;
        logic        rw;
        logic [7:0]  hi;
        logic [7:0]  wd;
        int          l_clk;
        int          h_clk;
        int          ack_at;   // request cycle that gets the ack, 0 = never
        logic [7:0]  rd;
        int          e_high;   // cycles mem_req stays high
        logic [7:0]  e_din;
        logic [15:0] e_cnt;
        logic        e_terr;
        logic        e_lerr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        clk_cpu;
    logic [7:0]  addr_pins;
    logic [7:0]  data_pins_out;
    logic [7:0]  data_pins_in;
    logic        timeout_err;
    logic        late_err;
    logic [15:0] cycle_count;

    ext_bus_bridge_if bus_if();

    ext_bus_bridge #(.TIMEOUT(TIMEOUT), .TIMEOUT_DATA(TIMEOUT_DATA)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_cpu       (clk_cpu),
        .addr_pins     (addr_pins),
        .data_pins_out (data_pins_out),
        .data_pins_in  (data_pins_in),
        .bus           (bus_if),
        .timeout_err   (timeout_err),
        .late_err      (late_err),
        .cycle_count   (cycle_count)
    );

    int          n_checks;
    int          n_fail;
    vec_t        vecs [NV];
    vec_t        rv;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wd;
    int          exp_high;
    int          ack_at;
    logic [7:0]  rd_val;
    int          req_cnt;
    logic [7:0]  m_din;
    logic [15:0] m_cnt;
    logic        m_terr;
    logic        m_lerr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks on the requested cycle of each request, checks
    // that the request fields stay correct and that the request lasts as long
    // as expected.
    initial begin
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 8'h00;
        req_cnt          = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.mem_req === 1'b1) begin
                req_cnt++;
                chk("mem_addr", 32'(bus_if.mem_addr), 32'(exp_addr));
                chk("mem_we", 32'(bus_if.mem_we), 32'(exp_we));
                chk("mem_wdata", 32'(bus_if.mem_wdata), 32'(exp_wd));
                bus_if.mem_ack   = (req_cnt == ack_at);
                bus_if.mem_rdata = bus_if.mem_ack ? rd_val : 8'($urandom);
            end else begin
                if (req_cnt != 0) begin
                    chk("mem_req_cycles", 32'(req_cnt), 32'(exp_high));
                end
                req_cnt        = 0;
                bus_if.mem_ack = 1'b0;
            end
        end
    end

    task automatic set_row(input int i, input logic [7:0] lo, input logic rw, input logic [7:0] hi,
                           input logic [7:0] wd, input int l, input int h, input int k,
                           input logic [7:0] rd, input int e_high, input logic [7:0] e_din,
                           input logic [15:0] e_cnt, input logic e_terr, input logic e_lerr);
        vecs[i].lo = lo;  vecs[i].rw = rw;  vecs[i].hi = hi;  vecs[i].wd = wd;
        vecs[i].l_clk = l;  vecs[i].h_clk = h;  vecs[i].ack_at = k;  vecs[i].rd = rd;
        vecs[i].e_high = e_high;  vecs[i].e_din = e_din;  vecs[i].e_cnt = e_cnt;
        vecs[i].e_terr = e_terr;  vecs[i].e_lerr = e_lerr;
    endtask

    // Outcome of one CPU cycle from the bridge rules: an ack that arrives
    // within TIMEOUT request cycles and before the CPU falls completes the
    // transfer; otherwise a high phase longer than TIMEOUT times out; else
    // the fall aborts it, still counting an ack on the very fall cycle.
    task automatic model_step(inout vec_t v);
        int  ack_eff;
        bit  done;
        bit  got;
        bit  timed;
        bit  late;
        ack_eff = (v.ack_at == 0) ? 1000 : v.ack_at;
        done = 1'b0;  got = 1'b0;  timed = 1'b0;  late = 1'b0;
        if (ack_eff <= TIMEOUT && ack_eff < v.h_clk) begin
            v.e_high = ack_eff;  done = 1'b1;  got = 1'b1;
        end else if (v.h_clk > TIMEOUT) begin
            v.e_high = TIMEOUT;  done = 1'b1;  timed = 1'b1;
        end else begin
            v.e_high = v.h_clk;  late = 1'b1;
            done = (ack_eff == v.h_clk);  got = done;
        end
        if (v.rw && got)   m_din = v.rd;
        if (v.rw && timed) m_din = TIMEOUT_DATA;
        if (done)          m_cnt = m_cnt + 16'd1;
        m_terr = m_terr | timed;
        m_lerr = m_lerr | late;
        v.e_din = m_din;  v.e_cnt = m_cnt;  v.e_terr = m_terr;  v.e_lerr = m_lerr;
    endtask

    task automatic lo_start(input logic [7:0] lo, input logic rw);
        clk_cpu       = 1'b0;
        addr_pins     = lo;
        data_pins_out = {7'b0000000, rw};
        tick();
    endtask

    // Finishes the low phase of v, runs its high phase, starts the next
    // cycle's low phase and checks the settled outcome.
    task automatic run_vec(input vec_t v, input logic [7:0] nlo, input logic nrw);
        repeat (v.l_clk - 1) tick();
        exp_addr = {v.hi, v.lo};
        exp_we   = ~v.rw;
        exp_wd   = v.wd;
        exp_high = v.e_high;
        ack_at   = v.ack_at;
        rd_val   = v.rd;
        clk_cpu       = 1'b1;
        addr_pins     = v.hi;
        data_pins_out = v.wd;
        repeat (v.h_clk) tick();
        lo_start(nlo, nrw);
        chk("data_pins_in", 32'(data_pins_in), 32'(v.e_din));
        chk("cycle_count", 32'(cycle_count), 32'(v.e_cnt));
        chk("timeout_err", 32'(timeout_err), 32'(v.e_terr));
        chk("late_err", 32'(late_err), 32'(v.e_lerr));
    endtask

    task automatic chk_reset_vals();
        chk("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus_if.mem_wdata), 32'd0);
        chk("rst_data_pins_in", 32'(data_pins_in), 32'd0);
        chk("rst_cycle_count", 32'(cycle_count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_late_err", 32'(late_err), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;  clk_cpu = 1'b1;  addr_pins = 8'h00;  data_pins_out = 8'h00;
        exp_addr = 16'h0000;  exp_we = 1'b0;  exp_wd = 8'h00;  exp_high = 0;
        ack_at = 0;  rd_val = 8'h00;

        //          idx lo     rw    hi     wd     L  H   k   rd     high din    cnt     terr  lerr
        set_row(0,  8'h34, 1'b1, 8'h12, 8'h00, 3, 8,  3,  8'hA9, 3,   8'hA9, 16'd1,  1'b0, 1'b0);
        set_row(1,  8'h00, 1'b0, 8'h02, 8'h5C, 2, 6,  2,  8'h77, 2,   8'hA9, 16'd2,  1'b0, 1'b0);
        set_row(2,  8'hFF, 1'b1, 8'hFF, 8'h11, 2, 4,  1,  8'h00, 1,   8'h00, 16'd3,  1'b0, 1'b0);
        set_row(3,  8'h80, 1'b1, 8'h7F, 8'h22, 2, 5,  4,  8'h3C, 4,   8'h3C, 16'd4,  1'b0, 1'b0);
        set_row(4,  8'h01, 1'b1, 8'h10, 8'h00, 2, 20, 0,  8'h00, 15,  8'hEA, 16'd5,  1'b1, 1'b0);
        set_row(5,  8'h02, 1'b0, 8'h20, 8'hA5, 3, 18, 0,  8'h00, 15,  8'hEA, 16'd6,  1'b1, 1'b0);
        set_row(6,  8'h03, 1'b1, 8'h30, 8'h00, 2, 6,  6,  8'hC3, 6,   8'hC3, 16'd7,  1'b1, 1'b1);
        set_row(7,  8'h04, 1'b1, 8'h40, 8'h00, 2, 4,  0,  8'h00, 4,   8'hC3, 16'd7,  1'b1, 1'b1);
        set_row(8,  8'h05, 1'b1, 8'h50, 8'h00, 2, 20, 15, 8'h5A, 15,  8'h5A, 16'd8,  1'b1, 1'b1);
        set_row(9,  8'h06, 1'b1, 8'h60, 8'h00, 2, 15, 0,  8'h00, 15,  8'h5A, 16'd8,  1'b1, 1'b1);
        set_row(10, 8'h07, 1'b0, 8'h70, 8'h99, 2, 3,  3,  8'hFF, 3,   8'h5A, 16'd9,  1'b1, 1'b1);

        m_din = vecs[NT-1].e_din;  m_cnt = vecs[NT-1].e_cnt;
        m_terr = vecs[NT-1].e_terr;  m_lerr = vecs[NT-1].e_lerr;
        for (int i = NT; i < NT + NR; i++) begin
            vecs[i].lo     = 8'($urandom);
            vecs[i].rw     = 1'($urandom);
            vecs[i].hi     = 8'($urandom);
            vecs[i].wd     = 8'($urandom);
            vecs[i].l_clk  = int'($urandom_range(4, 2));
            vecs[i].h_clk  = int'($urandom_range(20, 2));
            vecs[i].ack_at = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(18, 1));
            vecs[i].rd     = 8'($urandom);
            model_step(vecs[i]);
        end
        // Counter is preset to FFFE just before these two reads.
        m_cnt = 16'hFFFE;
        for (int i = WRAP_IDX; i < NV; i++) begin
            vecs[i].lo = 8'($urandom);  vecs[i].rw = 1'b1;  vecs[i].hi = 8'($urandom);
            vecs[i].wd = 8'h00;  vecs[i].l_clk = 3;  vecs[i].h_clk = 4;
            vecs[i].ack_at = 1;  vecs[i].rd = 8'($urandom);
            model_step(vecs[i]);
        end

        repeat (2) tick();
        chk_reset_vals();
        rst = 1'b0;
        // clk_cpu is high after reset: the apparent rise must not start anything.
        repeat (3) begin
            tick();
            chk("idle_no_req", 32'(bus_if.mem_req), 32'd0);
        end

        lo_start(vecs[0].lo, vecs[0].rw);
        for (int i = 0; i < NV; i++) begin
            if (i == WRAP_IDX) begin
                force dut.cycle_count = 16'hFFFE;
                tick();
                release dut.cycle_count;
            end
            if (i + 1 < NV) run_vec(vecs[i], vecs[i+1].lo, vecs[i+1].rw);
            else            run_vec(vecs[i], 8'h00, 1'b1);
        end

        // Reset in the middle of a request.
        tick();
        exp_addr = 16'hBB00;  exp_we = 1'b0;  exp_wd = 8'h00;  exp_high = 3;  ack_at = 0;
        clk_cpu = 1'b1;  addr_pins = 8'hBB;  data_pins_out = 8'h00;
        repeat (3) tick();
        chk("req_before_rst", 32'(bus_if.mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals();
        repeat (4) begin
            tick();
            chk("no_req_until_fall", 32'(bus_if.mem_req), 32'd0);
        end
        rv.lo = 8'h9A;  rv.rw = 1'b1;  rv.hi = 8'h21;  rv.wd = 8'h00;
        rv.l_clk = 2;  rv.h_clk = 5;  rv.ack_at = 2;  rv.rd = 8'h66;
        rv.e_high = 2;  rv.e_din = 8'h66;  rv.e_cnt = 16'd1;  rv.e_terr = 1'b0;  rv.e_lerr = 1'b0;
        lo_start(rv.lo, rv.rw);
        run_vec(rv, 8'h00, 1'b1);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
